// File: rtl/nabp_angle_lut.sv
// Angle-indexed constant table for NABP swap control: maps an angle index to the mapper
// partial/base and shifter base constants, registered with one cycle of latency.
module nabp_angle_lut #(
    parameter int unsigned ANGLE_WIDTH  = 8,
    parameter int unsigned NO_OF_ANGLES = 180,
    parameter int unsigned IMAGE_SIZE   = 256,
    parameter int unsigned FRAC         = 8,
    parameter int unsigned SH_W         = 9,
    parameter int unsigned MP_BASE_W    = 10,
    parameter int unsigned MP_PART_W    = 18
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [ANGLE_WIDTH-1:0]      angle,
    output logic signed [MP_PART_W-1:0] mp_accu_part,
    output logic signed [MP_BASE_W-1:0] mp_accu_base,
    output logic [SH_W-1:0]             sh_accu_base
);

    localparam int unsigned TAB_DEPTH = 2 ** ANGLE_WIDTH;
    localparam real         PI        = 3.14159265358979323846;
    localparam real         CENTRE    = (real'(IMAGE_SIZE) - 1.0) / 2.0;

    localparam longint SH_MAX   = (longint'(1) << SH_W) - 1;
    localparam longint BASE_MAX = (longint'(1) << (MP_BASE_W - 1)) - 1;
    localparam longint PART_MAX = (longint'(1) << (MP_PART_W - 1)) - 1;
    localparam longint PART_MIN = -(longint'(1) << (MP_PART_W - 1));

    // Round half away from zero after scaling to FRAC fixed point.
    function automatic longint q_round(input real v);
        real s;
        s = v * real'(longint'(1) << FRAC);
        if (s >= 0.0) begin
            return longint'($rtoi(s + 0.5));
        end
        return -longint'($rtoi(-s + 0.5));
    endfunction

    function automatic real abs_r(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    // Integer compare keeps the 45/135 degree boundaries exact.
    function automatic bit is_xmode(input longint a);
        return (a * 180 < 45 * longint'(NO_OF_ANGLES)) ||
               (a * 180 >= 135 * longint'(NO_OF_ANGLES));
    endfunction

    function automatic real theta_of(input longint a);
        return PI * real'(a) / real'(NO_OF_ANGLES);
    endfunction

    function automatic longint sh_val(input longint a);
        real sn;
        real cs;
        sn = $sin(theta_of(a));
        cs = $cos(theta_of(a));
        if (is_xmode(a)) begin
            return q_round(abs_r(sn / cs));
        end
        return q_round(abs_r(cs / sn));
    endfunction

    function automatic longint base_val(input longint a);
        if (is_xmode(a)) begin
            return q_round(abs_r($cos(theta_of(a))));
        end
        return q_round(abs_r($sin(theta_of(a))));
    endfunction

    function automatic longint part_val(input longint a);
        return q_round(CENTRE - CENTRE * ($cos(theta_of(a)) + $sin(theta_of(a))));
    endfunction

    logic [SH_W-1:0]             w_sh_tab   [TAB_DEPTH];
    logic signed [MP_BASE_W-1:0] w_base_tab [TAB_DEPTH];
    logic signed [MP_PART_W-1:0] w_part_tab [TAB_DEPTH];

    if (NO_OF_ANGLES > TAB_DEPTH) begin : g_depth_err
        $error("NO_OF_ANGLES does not fit ANGLE_WIDTH");
    end

    // Unused indices hold zero so out-of-range angles need no separate compare.
    for (genvar gi = 0; gi < TAB_DEPTH; gi++) begin : g_tab
        if (gi < NO_OF_ANGLES) begin : g_valid
            localparam longint SH_V   = sh_val(longint'(gi));
            localparam longint BASE_V = base_val(longint'(gi));
            localparam longint PART_V = part_val(longint'(gi));

            if (SH_V < 0 || SH_V > SH_MAX) begin : g_sh_ovf
                $error("sh_accu_base entry %0d overflows SH_W", gi);
            end
            if (BASE_V < 0 || BASE_V > BASE_MAX) begin : g_base_ovf
                $error("mp_accu_base entry %0d overflows MP_BASE_W", gi);
            end
            if (PART_V < PART_MIN || PART_V > PART_MAX) begin : g_part_ovf
                $error("mp_accu_part entry %0d overflows MP_PART_W", gi);
            end

            assign w_sh_tab[gi]   = SH_W'(SH_V);
            assign w_base_tab[gi] = MP_BASE_W'(BASE_V);
            assign w_part_tab[gi] = MP_PART_W'(PART_V);
        end else begin : g_zero
            assign w_sh_tab[gi]   = '0;
            assign w_base_tab[gi] = '0;
            assign w_part_tab[gi] = '0;
        end
    end

    logic [SH_W-1:0]             r_sh;
    logic signed [MP_BASE_W-1:0] r_base;
    logic signed [MP_PART_W-1:0] r_part;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sh   <= '0;
            r_base <= '0;
            r_part <= '0;
        end else begin
            r_sh   <= w_sh_tab[angle];
            r_base <= w_base_tab[angle];
            r_part <= w_part_tab[angle];
        end
    end

    assign sh_accu_base = r_sh;
    assign mp_accu_base = r_base;
    assign mp_accu_part = r_part;

endmodule

// File: tb/tb_nabp_angle_lut.sv
// Bench for nabp_angle_lut: directed angle/reset steps push expected outputs into a
// queue tagged with the edge they belong to; a monitor compares after each edge.
module tb_nabp_angle_lut;

    logic               clk;
    logic               reset_n;
    logic [7:0]         angle;
    logic signed [17:0] mp_accu_part;
    logic signed [9:0]  mp_accu_base;
    logic [8:0]         sh_accu_base;

    nabp_angle_lut dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .angle        (angle),
        .mp_accu_part (mp_accu_part),
        .mp_accu_base (mp_accu_base),
        .sh_accu_base (sh_accu_base)
    );

    typedef struct {
        int                 cyc;
        int                 step_id;
        logic [8:0]         sh;
        logic signed [9:0]  base;
        logic signed [17:0] part;
    } exp_t;

    exp_t exp_q[$];
    int   cyc_cnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_steps = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Each step drives after edge k and expects its result right after edge k+1.
    task automatic step(input logic [7:0] a, input logic rst_n,
                        input int sh, input int base, input int part);
        exp_t e;
        @(posedge clk);
        #1;
        angle   = a;
        reset_n = rst_n;
        e.cyc     = cyc_cnt + 1;
        e.step_id = n_steps;
        e.sh      = 9'(sh);
        e.base    = 10'(base);
        e.part    = 18'(part);
        exp_q.push_back(e);
        n_steps++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
            n_checks++;
            n_errors++;
            $display("FAIL missed_slot step=%0d got_cycle=%0d required_cycle=%0d",
                     exp_q[0].step_id, cyc_cnt, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (sh_accu_base !== e.sh) begin
                n_errors++;
                $display("FAIL sh_accu_base step=%0d got=%0d required=%0d",
                         e.step_id, sh_accu_base, e.sh);
            end
            n_checks++;
            if (mp_accu_base !== e.base) begin
                n_errors++;
                $display("FAIL mp_accu_base step=%0d got=%0d required=%0d",
                         e.step_id, mp_accu_base, e.base);
            end
            n_checks++;
            if (mp_accu_part !== e.part) begin
                n_errors++;
                $display("FAIL mp_accu_part step=%0d got=%0d required=%0d",
                         e.step_id, mp_accu_part, e.part);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        angle   = 8'd0;

        // Reset state
        step(8'd0,   1'b0, 0, 0, 0);
        step(8'd0,   1'b0, 0, 0, 0);
        // Lookups
        step(8'd0,   1'b1, 0, 256, 0);
        step(8'd30,  1'b1, 148, 222, -11947);
        step(8'd45,  1'b1, 256, 181, -13520);
        step(8'd90,  1'b1, 0, 256, 0);
        step(8'd135, 1'b1, 256, 181, 32640);
        step(8'd179, 1'b1, 4, 256, 64705);
        step(8'd180, 1'b1, 0, 0, 0);
        step(8'd30,  1'b1, 148, 222, -11947);
        step(8'd200, 1'b1, 0, 0, 0);
        // Reset mid-stream
        step(8'd30,  1'b0, 0, 0, 0);
        step(8'd30,  1'b0, 0, 0, 0);
        step(8'd30,  1'b1, 148, 222, -11947);
        step(8'd45,  1'b0, 0, 0, 0);
        step(8'd90,  1'b1, 0, 256, 0);
        step(8'd135, 1'b1, 256, 181, 32640);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
